// File: rtl/mac_tc_16_16_acc_if.sv
// Operand-pair stream in, dot-product result stream out, both valid/ready.
// The master side feeds operands and consumes results; the MAC is the slave.
interface mac_tc_16_16_acc_if #(
  parameter int ACC_W = 40
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      a;
  logic signed [15:0]      b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    ovf;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mac_tc_16_16_acc.sv
// Pipelined signed 16x16 multiply-accumulate: one wrap-around dot product per
// in_last-terminated vector, with a sticky signed-overflow flag per vector.
module mac_tc_16_16_acc #(
  parameter int ACC_W = 40
) (
  input logic                clk,
  input logic                rst,
  mac_tc_16_16_acc_if.slave  bus
);
  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  function automatic logic signed [PROD_W-1:0] mul_tc_16_16(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    return PROD_W'(x) * PROD_W'(y);
  endfunction

  // Overflow of a wrap-around add: equal operand signs, result sign differs.
  function automatic logic add_ovf(
    input logic signed [ACC_W-1:0] lhs,
    input logic signed [ACC_W-1:0] rhs,
    input logic signed [ACC_W-1:0] res
  );
    return (lhs[ACC_W-1] == rhs[ACC_W-1]) && (res[ACC_W-1] != lhs[ACC_W-1]);
  endfunction

  logic                     en;
  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic signed [PROD_W-1:0] prod_p2;
  logic                     vld_p2;
  logic                     last_p2;
  logic signed [ACC_W-1:0]  acc_p3;
  logic                     ovf_acc_p3;
  logic signed [ACC_W-1:0]  acc_out_q;
  logic                     ovf_q;
  logic                     out_valid_q;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     step_ovf;

  // A single enable freezes the whole pipe while a result waits downstream.
  assign en = !out_valid_q || bus.out_ready;

  assign prod_ext = ACC_W'(prod_p2);
  assign sum      = acc_p3 + prod_ext;
  assign step_ovf = add_ovf(acc_p3, prod_ext, sum);

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p1        <= '0;
      b_p1        <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      prod_p2     <= '0;
      vld_p2      <= 1'b0;
      last_p2     <= 1'b0;
      acc_p3      <= '0;
      ovf_acc_p3  <= 1'b0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      // P1: operand capture; a missing in_valid becomes a bubble
      a_p1    <= bus.a;
      b_p1    <= bus.b;
      vld_p1  <= bus.in_valid;
      last_p1 <= bus.in_last;

      // P2: product
      prod_p2 <= mul_tc_16_16(a_p1, b_p1);
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;

      // ACC: accumulate, or publish and restart on the last element.
      // en high with out_valid set implies out_ready, so the old result is gone.
      out_valid_q <= 1'b0;
      if (vld_p2) begin
        if (last_p2) begin
          acc_out_q   <= sum;
          ovf_q       <= ovf_acc_p3 | step_ovf;
          out_valid_q <= 1'b1;
          acc_p3      <= '0;
          ovf_acc_p3  <= 1'b0;
        end else begin
          acc_p3     <= sum;
          ovf_acc_p3 <= ovf_acc_p3 | step_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_tc_16_16_acc.sv
// Self-checking bench for mac_tc_16_16_acc: directed vector table, overflow,
// backpressure, reset mid-vector and a random stream against a wide-integer model.
module tb_mac_tc_16_16_acc;
  localparam int ACC_W = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_tc_16_16_acc_if #(.ACC_W(ACC_W)) bus ();
  mac_tc_16_16_acc #(.ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    longint acc;
    logic   ovf;
    int     cyc;
  } res_t;

  typedef struct {
    int     a;
    int     b;
    logic   last;
    longint exp_acc;
    logic   exp_ovf;
    string  name;
  } vec_t;

  res_t got_q[$];
  res_t exp_q[$];
  int   cyc = 0;
  int   vcount = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  longint m_acc = 0;
  logic   m_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: observes both handshakes mid-cycle and runs the reference model.
  always @(negedge clk) begin : mon
    longint p, full, lim;
    logic step;
    logic signed [ACC_W-1:0] w;
    if (rst) begin
      m_acc <= 0;
      m_ovf <= 1'b0;
    end else begin
      if (bus.out_valid) vcount <= vcount + 1;
      if (bus.out_valid && bus.out_ready)
        got_q.push_back('{longint'(bus.acc_out), bus.ovf, cyc});
      if (bus.in_valid && bus.in_ready) begin
        p    = longint'(bus.a) * longint'(bus.b);
        full = m_acc + p;
        lim  = longint'(1) <<< (ACC_W - 1);
        step = (full >= lim) || (full < -lim);
        w    = full[ACC_W-1:0];
        if (bus.in_last) begin
          exp_q.push_back('{longint'(w), m_ovf | step, 0});
          m_acc <= 0;
          m_ovf <= 1'b0;
        end else begin
          m_acc <= longint'(w);
          m_ovf <= m_ovf | step;
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Drive one pair from just after a rising edge; return at the mid-cycle
  // point where the upcoming edge is known to accept it.
  task automatic send(input int av, input int bv, input logic lv);
    int guard = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = 16'(av);
    bus.b        = 16'(bv);
    bus.in_last  = lv;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      guard++;
      if (guard >= 200) begin
        timeout("send");
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    int guard = 0;
    while (got_q.size() < n) begin
      @(posedge clk); #1;
      guard++;
      if (guard >= 200) begin
        timeout(name);
        break;
      end
    end
  endtask

  task automatic pop_check(input string name, input longint exp_acc, input logic exp_ovf,
                           output int rcyc);
    res_t r;
    rcyc = -1;
    if (got_q.size() == 0) begin
      timeout({name, " result"});
    end else begin
      r = got_q.pop_front();
      rcyc = r.cyc;
      check({name, " acc_out"}, r.acc, exp_acc);
      check({name, " ovf"}, longint'(r.ovf), longint'(exp_ovf));
    end
  endtask

  vec_t vt[6];

  initial begin
    int t_acc, rc, v0, guard, sent;
    bit pend;
    res_t g, e;

    vt[0] = '{3, 4, 1'b0, 0, 1'b0, "dot"};
    vt[1] = '{-5, 6, 1'b0, 0, 1'b0, "dot"};
    vt[2] = '{7, -8, 1'b1, -74, 1'b0, "dot"};
    vt[3] = '{-32768, -32768, 1'b1, 64'sh0040000000, 1'b0, "minmin"};
    vt[4] = '{-32768, 32767, 1'b1, -64'sd1073709056, 1'b0, "minmax"};
    vt[5] = '{0, -1, 1'b1, 0, 1'b0, "zero"};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", longint'(bus.out_valid), 0);
    check("rst acc_out", longint'(bus.acc_out), 0);
    check("rst ovf", longint'(bus.ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", longint'(bus.in_ready), 1);

    // Directed table: each vector drained before the next, to check pulse width.
    v0 = vcount;
    for (int i = 0; i < 6; i++) begin
      send(vt[i].a, vt[i].b, vt[i].last);
      if (vt[i].last) begin
        t_acc = cyc + 1;
        idle();
        wait_got(1, vt[i].name);
        pop_check(vt[i].name, vt[i].exp_acc, vt[i].exp_ovf, rc);
        check({vt[i].name, " latency"}, longint'(rc - t_acc), 2);
        repeat (4) @(posedge clk);
        #1;
        check({vt[i].name, " valid cycles"}, longint'(vcount - v0), 1);
        v0 = vcount;
      end
    end

    // Overflow bound: 511 extreme products fit, the 512th wraps.
    for (int i = 0; i < 511; i++) send(-32768, -32768, i == 510);
    idle();
    wait_got(1, "ovf511");
    pop_check("ovf511", 64'sd548682072064, 1'b0, rc);
    for (int i = 0; i < 512; i++) send(-32768, -32768, i == 511);
    idle();
    wait_got(1, "ovf512");
    pop_check("ovf512", -64'sd549755813888, 1'b1, rc);
    send(1, 1, 1'b1);
    idle();
    wait_got(1, "after ovf");
    pop_check("after ovf", 1, 1'b0, rc);

    // Backpressure: first result held while the second waits in the pipe.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(2, 3, 1'b1);
    send(4, 5, 1'b1);
    idle();
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) timeout("bp out_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp held acc_out", longint'(bus.acc_out), 6);
      check("bp held valid", longint'(bus.out_valid), 1);
      check("bp in_ready", longint'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_got(2, "bp drain");
    pop_check("bp first", 6, 1'b0, rc);
    pop_check("bp second", 20, 1'b0, rc);

    // Random stream against the monitor's model.
    repeat (4) @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    sent = 0;
    pend = 1'b0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.in_last = (sent == 999) || ($urandom_range(0, 7) == 0);
      end
      bus.in_valid = pend;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        pend = 1'b0;
        sent++;
      end
    end
    if (sent < 1000) timeout("random stream");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    wait_got(exp_q.size(), "random drain");
    check("random count", longint'(got_q.size()), longint'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("random acc_out", g.acc, e.acc);
      check("random ovf", longint'(g.ovf), longint'(e.ovf));
    end

    // Reset mid-vector discards the partial sum and in-flight pairs.
    send(100, 100, 1'b0);
    send(50, 50, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid-rst out_valid", longint'(bus.out_valid), 0);
    check("mid-rst acc_out", longint'(bus.acc_out), 0);
    check("mid-rst ovf", longint'(bus.ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    send(2, 2, 1'b1);
    idle();
    wait_got(1, "after rst");
    pop_check("after rst", 4, 1'b0, rc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mac_tc_16_16_acc.md
# mac_tc_16_16_acc

Pipelined two's-complement multiply-accumulate stage that consumes the 32-bit signed product of the combinational `mul_tc_16_16` multiplier. Streams of signed 16-bit operand pairs arrive over a valid/ready handshake. Each pair is registered, multiplied by an internal `mul_tc_16_16` instance, and the product is registered and summed into a wide signed accumulator. One dot-product result is emitted per vector, with the vector end marked by `in_last`, over a second valid/ready handshake.

## Interface
- `ACC_W`, default 40: accumulator and result width. Must be at least 32; the default gives 8 guard bits.
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept a pair this cycle.
- `a`, input, 16: signed multiplicand.
- `b`, input, 16: signed multiplier.
- `in_last`, input, 1: this pair is the final element of the current vector.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream accepts the result.
- `acc_out`, output, ACC_W: signed sum of products for the vector.
- `ovf`, output, 1: signed overflow occurred at least once during this vector's accumulation.

## Operation
- **Stage P1:** registers `a_r`, `b_r`, `v1`, `last1`.
- **Stage P2:** registers `p_r = mul_tc_16_16(a_r, b_r)` (32 bits), `v2`, `last2`.
- **Stage ACC:**
  - When `v2` is set: `sum = acc + sext(p_r)`, computed in ACC_W bits with wrap-around.
  - `ovf_acc |= (sign(acc) == sign(p_r)) && (sign(sum) != sign(acc))`.
  - If `last2` is clear: `acc <= sum`.
  - If `last2` is set:
    - `acc_out <= sum` and `ovf <= ovf_acc | this_step_ovf`.
    - `out_valid <= 1`.
    - `acc <= 0` and `ovf_acc <= 0`, so the next vector starts from zero.
- **Global advance enable:** `en = !out_valid || out_ready`.
  - `in_ready = en`.
  - P1, P2 and ACC update only when `en` is high.
  - When `en` is low, every register holds its value.
- **Input accept:** a pair is accepted when `in_valid && in_ready`. When `en` is high and `in_valid` is low, a bubble (`v1 = 0`) enters P1.
- **Output handshake:**
  - On `out_valid && out_ready`, the result is consumed.
  - `out_valid` falls unless a new last-result loads on the same edge. In that case `acc_out`/`ovf` update and `out_valid` stays high.
- **Held output:** `acc_out` and `ovf` are stable while `out_valid && !out_ready`.
- **Reset values:** all registers are 0. That gives `out_valid = 0`, `acc_out = 0`, `ovf = 0`, and `in_ready = 1` from the first cycle after reset.
- **Reset mid-vector:** any partial accumulation and in-flight pairs are discarded. The first pair after reset starts a new vector.
- **Single-element vector:** a pair with `in_last = 1` yields its product sign-extended.

## Timing
- **Latency:** a pair accepted at edge k reaches P1 at k, P2 at k+1, and ACC at k+2. With no stall, `out_valid` is high after edge k+2 for a last element.
- **Throughput:** one pair per cycle, with back-to-back vectors allowed. The last element of vector n and the first of vector n+1 may be accepted on consecutive edges.
- **Stall:** while `out_valid && !out_ready`, `in_ready` is 0 and no pair is lost or duplicated. When `out_ready` rises, advance resumes on that same edge.
- **Overflow bound:** the extreme product is (-32768)·(-32768) = 2^30. With ACC_W = 40, 511 such products are safe and the 512th overflows.

## Test plan
- **Basic dot product:** vector (3,4), (-5,6), (7,-8 with last), sent back-to-back with `out_ready = 1`.
  - Required: `acc_out` = -74 = 0xFFFFFFFFB6, `ovf` = 0.
  - Required: `out_valid` high for exactly one cycle, 2 edges after the last accept.
- **Corner operands:** single-element vectors with `out_ready = 1`.
  - (-32768,-32768) -> 0x0040000000.
  - (-32768,32767) -> 0xFFC0008000.
  - (0,-1) -> 0x0000000000.
  - Required: `ovf` = 0 for all three.
- **Overflow:**
  - 511 × (-32768,-32768) -> 548682072064 (0x7FC0000000), `ovf` = 0.
  - 512 × (-32768,-32768) -> 0x8000000000, `ovf` = 1.
  - Next vector (1,1 with last) -> 1, `ovf` = 0.
- **Backpressure:**
  - Stimulus: two back-to-back vectors, (2,3 last) then (4,5 last), with `out_ready` held 0 for 5 cycles.
  - Required: the first result, 6, is held stable while stalled and `in_ready` is 0.
  - Required: once `out_ready` rises, 6 then 20 are delivered in order with no loss.
- **Random stream:** 1000 random pairs with random `in_last` (about 1 in 8), random `in_valid`/`out_ready`, run against a reference model.
  - Required: every `acc_out` and `ovf` matches the model.
- **Reset mid-vector:**
  - Stimulus: accept (100,100) and (50,50), assert `rst` for 1 cycle, then send (2,2 last).
  - Required: the result is 4, not 12504. All outputs are 0 during reset.
